// File: rtl/kentrane_tinymusical_pkg.sv
// Shared types and constants for the tiny musical tone generator: input field layout,
// output bit positions and the note half-period table derived from the clock frequency.
package kentrane_tinymusical_pkg;

  localparam int NOTE_COUNT = 12;
  localparam int HALF_W     = 15;

  // uo_out bit positions
  localparam int UO_AUDIO    = 0;
  localparam int UO_NOTE_LSB = 1;
  localparam int UO_OCT_LSB  = 5;
  localparam int UO_PLAYING  = 7;

  typedef struct packed {
    logic       trem;
    logic       enable;
    logic [1:0] octave;
    logic [3:0] note;
  } ui_t;

  // Octave-4 note frequencies in millihertz, C..B
  localparam int unsigned NOTE_MHZ [NOTE_COUNT] = '{
    261626, 277183, 293665, 311127, 329628, 349228,
    369994, 391995, 415305, 440000, 466164, 493883
  };

  // round(clk_hz / (2*f)) in clocks, done in integer millihertz to stay exact
  function automatic logic [HALF_W-1:0] note_half(input longint unsigned clk_hz,
                                                  input int unsigned note);
    longint unsigned f2;
    f2 = 64'd2 * longint'(NOTE_MHZ[note]);
    return HALF_W'((clk_hz * 64'd1000 + f2 / 64'd2) / f2);
  endfunction

endpackage

// File: rtl/kentrane_tinymusical_tone_divider.sv
// Note/octave to half-period lookup plus the square-wave counter and toggle flop.
// A >= compare lets a switch to a shorter period wrap on the very next cycle.
module kentrane_tinymusical_tone_divider
  import kentrane_tinymusical_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       playing,
  input  logic [3:0] note,
  input  logic [1:0] octave,
  output logic       audio_q
);

  localparam logic [HALF_W-1:0] ONE = HALF_W'(1);

  logic [HALF_W-1:0] half_tbl [NOTE_COUNT];
  logic [HALF_W-1:0] half;
  logic [HALF_W-1:0] half_m1;
  logic [HALF_W-1:0] cnt_q;

  for (genvar g = 0; g < NOTE_COUNT; g++) begin : g_tbl
    assign half_tbl[g] = note_half(longint'(CLK_HZ), g);
  end

  always_comb begin
    half = '0;
    if (note < 4'(NOTE_COUNT)) half = half_tbl[note] >> octave;
    half_m1 = half - ONE;
  end

  // Not playing forces both counter and flop to 0, so a restart begins a fresh low phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      audio_q <= 1'b0;
    end else if (!playing) begin
      cnt_q   <= '0;
      audio_q <= 1'b0;
    end else if (cnt_q >= half_m1) begin
      cnt_q   <= '0;
      audio_q <= ~audio_q;
    end else begin
      cnt_q   <= cnt_q + ONE;
    end
  end

endmodule

// File: rtl/kentrane_tinymusical.sv
// Tile top: registers ui_in, runs the tremolo LFO and decodes uo_out from registered state.
// The bidirectional pins are unused and left as inputs.
module kentrane_tinymusical
  import kentrane_tinymusical_pkg::*;
#(
  parameter int CLK_HZ    = 10_000_000,
  parameter int TREM_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  ui_t                  in_q;
  logic [TREM_BITS-1:0] lfo_q;
  logic                 playing;
  logic                 audio_q;
  logic                 lfo;
  logic                 unused_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      lfo_q <= '0;
    end else begin
      in_q  <= ui_t'(ui_in);
      lfo_q <= lfo_q + TREM_BITS'(1);
    end
  end

  assign playing = in_q.enable & (in_q.note < 4'(NOTE_COUNT));
  assign lfo     = lfo_q[TREM_BITS-1];

  kentrane_tinymusical_tone_divider #(
    .CLK_HZ(CLK_HZ)
  ) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .playing(playing),
    .note   (in_q.note),
    .octave (in_q.octave),
    .audio_q(audio_q)
  );

  // Tremolo mutes the tone during the low half of the LFO cycle
  always_comb begin
    uo_out                      = '0;
    uo_out[UO_AUDIO]            = audio_q & (~in_q.trem | lfo);
    uo_out[UO_NOTE_LSB +: 4]    = playing ? in_q.note : 4'd0;
    uo_out[UO_OCT_LSB +: 2]     = in_q.octave;
    uo_out[UO_PLAYING]          = playing;
  end

  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_in = &{1'b0, ena, uio_in};

endmodule

// File: tb/tb_kentrane_tinymusical.sv
// Directed bench for the tone generator: reset, note/octave periods, rest/disable,
// period shrink, asynchronous reset mid-tone and tremolo gating (short LFO for sim time).
module tb_kentrane_tinymusical;

  localparam int TREM_BITS = 14;
  localparam int LIMIT     = 30000;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_pass;

  kentrane_tinymusical #(
    .CLK_HZ   (10_000_000),
    .TREM_BITS(TREM_BITS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Count rising clock edges until audio reaches level; returns LIMIT on timeout
  task automatic wait_audio(input logic level, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (uo_out[0] !== level && n < LIMIT);
  endtask

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    ui_in = v;
  endtask

  task automatic step_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int highs;
    n_checks = 0;
    n_pass   = 0;
    ena      = 1'b1;
    uio_in   = 8'h00;
    ui_in    = 8'hFF;
    rst_n    = 1'b0;

    // Reset with all inputs high
    repeat (3) @(posedge clk);
    #1;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step_sample();
    check("post_rst_ff", uo_out, 8'h60);  // note 15 is a rest; only octave bits show

    // A4: half 11364
    drive(8'h49);
    step_sample();
    check("a4_leds", uo_out, 8'h92);
    wait_audio(1'b1, n); check("a4_first_rise", n, 11364);
    wait_audio(1'b0, n); check("a4_fall", n, 11364);

    // Disable while high: audio low after the input register and divider catch up
    wait_audio(1'b1, n);
    drive(8'h09);
    repeat (2) @(posedge clk);
    #1;
    check("disable_mid_tone", uo_out, 8'h00);

    // Re-enable restarts from counter 0
    drive(8'h49);
    step_sample();
    check("reenable_leds", uo_out, 8'h92);
    wait_audio(1'b1, n); check("reenable_first_rise", n, 11364);

    // A octave 3: half 1420
    drive(8'h00);
    repeat (2) @(posedge clk);
    drive(8'h79);
    step_sample();
    check("a_oct3_leds", uo_out, 8'hF2);
    wait_audio(1'b1, n); check("a_oct3_rise", n, 1420);
    wait_audio(1'b0, n); check("a_oct3_fall", n, 1420);

    // C octave 3: half 2388
    drive(8'h00);
    repeat (2) @(posedge clk);
    drive(8'h70);
    step_sample();
    check("c_oct3_leds", uo_out, 8'hE0);
    wait_audio(1'b1, n); check("c_oct3_rise", n, 2388);
    wait_audio(1'b0, n); check("c_oct3_fall", n, 2388);

    // Rest note with enable set
    drive(8'h5C);
    repeat (2) @(posedge clk);
    #1;
    check("rest_note12", uo_out, 8'h20);

    // C oct0 part-way through a low phase, then switch to B oct3 (half 1265)
    drive(8'h40);
    step_sample();
    check("c_oct0_leds", uo_out, 8'h80);
    repeat (5000) @(posedge clk);
    drive(8'h7B);
    wait_audio(1'b1, n); check("shrink_wrap_next", n, 2);
    wait_audio(1'b0, n); check("shrink_fall", n, 1265);
    wait_audio(1'b1, n); check("shrink_rise", n, 1265);

    // Asynchronous reset while audio is high
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mid_tone", uo_out, 8'h00);

    // Tremolo on B oct3: silent while LFO MSB is low (first 2^13 clocks)
    ui_in = 8'hFB;
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 8000; i++) begin
      step_sample();
      if (uo_out[0] === 1'b1) highs++;
    end
    check("trem_silent_highs", highs, 0);
    check("trem_leds", uo_out, 8'hF6);
    highs = 0;
    for (int i = 0; i < 8000; i++) begin
      step_sample();
      if (uo_out[0] === 1'b1) highs++;
    end
    check("trem_resumes", (highs != 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
